// File: rtl/posit_defines.sv
// Shared posit record width functions used by every stage that produces or consumes a decoded record.
package posit_defines;

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    WIDE   = 1'b1
  } pd_type;

  function automatic int get_max_scale(input int n, input int es);
    return (n - 2) << es;
  endfunction

  // Two spare bits so arithmetic stages can hand over out-of-range scales for clamping.
  function automatic int get_scale_width(input int n, input int es, input pd_type t);
    int w;
    w = $clog2(get_max_scale(n, es) + 1) + 2;
    return (t == WIDE) ? w + 2 : w;
  endfunction

  function automatic int get_fraction_width(input int n, input int es, input pd_type t);
    int w;
    w = n - 2 - es;
    if (w < 1) w = 1;
    return (t == WIDE) ? 2 * n : w;
  endfunction

endpackage

// File: rtl/posit_pd_encode_if.sv
// Decoded posit record carried between arithmetic stages and the encoder.
interface pd
  import posit_defines::*;
#(
   parameter int     POSIT_WIDTH = 8,
   parameter int     POSIT_ES    = 0,
   parameter pd_type PD_TYPE     = NORMAL
) ();
   localparam int SW = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);
   localparam int FW = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE);

   logic signed [SW-1:0] scale;
   logic [FW-1:0]        fraction;
   logic                 nar;
   logic                 sign;
   logic                 zero;
   logic                 guard_bit;
   logic                 round_bit;
   logic                 sticky;

   modport master (output scale, fraction, nar, sign, zero, guard_bit, round_bit, sticky);
   modport slave  (input  scale, fraction, nar, sign, zero, guard_bit, round_bit, sticky);
endinterface

// File: rtl/posit_regime_pack.sv
// Builds regime|exponent|fraction|guard|round, truncates to N-1 bits and returns the rounding bits.
module posit_regime_pack
  import posit_defines::*;
#(
   parameter int     POSIT_WIDTH = 8,
   parameter int     POSIT_ES    = 0,
   parameter pd_type PD_TYPE     = NORMAL,
   localparam int    N           = POSIT_WIDTH,
   localparam int    SW          = get_scale_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
   localparam int    FW          = get_fraction_width(POSIT_WIDTH, POSIT_ES, PD_TYPE),
   localparam int    EW          = (POSIT_ES > 0) ? POSIT_ES : 1
) (
   input  logic signed [SW-1:0] k,
   input  logic [EW-1:0]        e,
   input  logic [FW-1:0]        fraction,
   input  logic                 guard_bit,
   input  logic                 round_bit,
   input  logic                 sticky,
   output logic [N-2:0]         body,
   output logic                 g,
   output logic                 s
);
   localparam int TW = POSIT_ES + FW + 2;
   localparam int W  = N - 1 + FW + POSIT_ES + 3;
   localparam logic [W-1:0] ONES    = {W{1'b1}};
   localparam logic [W-1:0] TOP_ONE = {1'b1, {(W-1){1'b0}}};

   logic [TW-1:0]  tail;
   logic [W-1:0]   aligned;
   logic [W-1:0]   field;
   logic [SW-1:0]  shamt;

   // The regime is at most N bits long, so the tail is parked N bits down and shifted past it.
   always_comb begin
      tail    = TW'({fraction, guard_bit, round_bit}) | (TW'(e) << (FW + 2));
      aligned = {tail, {N{1'b0}}};
      if (!k[SW-1]) begin
         shamt = k + SW'(1);
         field = ~(ONES >> shamt) | (aligned >> (shamt + SW'(1)));
      end else begin
         shamt = SW'(-k);
         field = (TOP_ONE >> shamt) | (aligned >> (shamt + SW'(1)));
      end
      body = field[W-1 -: N-1];
      g    = field[W-N];
      s    = (|field[W-N-1:0]) | sticky;
   end
endmodule

// File: rtl/posit_pd_encode.sv
// Three-stage round-to-nearest-even posit encoder with a single global stall.
module posit_pd_encode
  import posit_defines::*;
#(
   parameter int     POSIT_WIDTH = 8,
   parameter int     POSIT_ES    = 0,
   parameter pd_type PD_TYPE     = NORMAL
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   pd.slave                       in_pd,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [POSIT_WIDTH-1:0] out_posit
);
   localparam int N  = POSIT_WIDTH;
   localparam int ES = POSIT_ES;
   localparam int SW = get_scale_width(N, ES, PD_TYPE);
   localparam int FW = get_fraction_width(N, ES, PD_TYPE);
   localparam int EW = (ES > 0) ? ES : 1;
   localparam logic signed [SW-1:0] MAXS_S = SW'(get_max_scale(N, ES));
   localparam logic signed [SW-1:0] MINS_S = SW'(-get_max_scale(N, ES));
   localparam logic [EW-1:0]        E_MASK = EW'((1 << ES) - 1);

   typedef struct packed {
      logic                 valid;
      logic                 nar;
      logic                 zero;
      logic                 sign;
      logic                 clamped_hi;
      logic                 clamped_lo;
      logic signed [SW-1:0] k;
      logic [EW-1:0]        e;
      logic [FW-1:0]        frac;
      logic                 guard_bit;
      logic                 round_bit;
      logic                 sticky;
   } s1_t;

   typedef struct packed {
      logic         valid;
      logic         nar;
      logic         zero;
      logic         sign;
      logic         clamped_lo;
      logic [N-2:0] body;
      logic         inc;
   } s2_t;

   s1_t s1_d, s1_q;
   s2_t s2_d, s2_q;
   logic         out_valid_d, out_valid_q;
   logic [N-1:0] out_posit_d, out_posit_q;
   logic signed [SW-1:0] scale_c;
   logic [N-2:0] pk_body;
   logic         pk_g, pk_s;
   logic [N-2:0] mag;
   logic [N-1:0] word;
   logic         en;

   assign en        = ~out_valid_q | out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_q;
   assign out_posit = out_posit_q;

   // S1: clamp the scale and split it into regime run length and exponent.
   always_comb begin
      s1_d    = s1_q;
      scale_c = in_pd.scale;
      if (in_pd.scale > MAXS_S)      scale_c = MAXS_S;
      else if (in_pd.scale < MINS_S) scale_c = MINS_S;
      if (en) begin
         s1_d.valid      = in_valid;
         s1_d.nar        = in_pd.nar;
         s1_d.zero       = in_pd.zero;
         s1_d.sign       = in_pd.sign;
         s1_d.clamped_hi = in_pd.scale > MAXS_S;
         s1_d.clamped_lo = in_pd.scale < MINS_S;
         s1_d.k          = scale_c >>> ES;
         s1_d.e          = EW'(scale_c) & E_MASK;
         s1_d.frac       = in_pd.fraction;
         s1_d.guard_bit  = in_pd.guard_bit;
         s1_d.round_bit  = in_pd.round_bit;
         s1_d.sticky     = in_pd.sticky;
      end
   end

   posit_regime_pack #(
      .POSIT_WIDTH (POSIT_WIDTH),
      .POSIT_ES    (POSIT_ES),
      .PD_TYPE     (PD_TYPE)
   ) u_pack (
      .k         (s1_q.k),
      .e         (s1_q.e),
      .fraction  (s1_q.frac),
      .guard_bit (s1_q.guard_bit),
      .round_bit (s1_q.round_bit),
      .sticky    (s1_q.sticky | s1_q.clamped_hi),
      .body      (pk_body),
      .g         (pk_g),
      .s         (pk_s)
   );

   always_comb begin
      s2_d = s2_q;
      if (en) begin
         s2_d.valid      = s1_q.valid;
         s2_d.nar        = s1_q.nar;
         s2_d.zero       = s1_q.zero;
         s2_d.sign       = s1_q.sign;
         s2_d.clamped_lo = s1_q.clamped_lo;
         s2_d.body       = pk_body;
         s2_d.inc        = pk_g & (pk_s | pk_body[0]);
      end
   end

   // S3: saturate at maxpos, never round to zero, then apply sign and special values.
   always_comb begin
      mag = s2_q.body + ((&s2_q.body) ? {(N-1){1'b0}} : (N-1)'(s2_q.inc));
      if (s2_q.clamped_lo || mag == '0) mag = (N-1)'(1);
      word = {1'b0, mag};
      if (s2_q.sign)      word = -word;
      if (s2_q.nar)       word = {1'b1, {(N-1){1'b0}}};
      else if (s2_q.zero) word = '0;
      out_valid_d = out_valid_q;
      out_posit_d = out_posit_q;
      if (en) begin
         out_valid_d = s2_q.valid;
         out_posit_d = word;
      end
   end

   // NOTE: state uses non-blocking assignments so every stage samples the previous stage's old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q        <= '0;
         s2_q        <= '0;
         out_valid_q <= 1'b0;
         out_posit_q <= '0;
      end else begin
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         out_valid_q <= out_valid_d;
         out_posit_q <= out_posit_d;
      end
   end
endmodule
